dac_power_sequencer: RTL and testbench

Controller that sequences the three segmented video DACs (red, green, blue) through bias power-up, streaming and power-down. It stages each channel's three bias enables in turn, then accepts 24-bit RGB pixels over a valid/ready handshake. Each 8-bit channel value is converted to the 12-bit segmented switch code (4 segments × 3 thermometer switches). It sits between the digital pixel source and the analog control wrapper that drives the DAC switch and bias nets.

---
 rtl/dac_seq_pkg.sv | 17 +
 rtl/dac_power_sequencer_seg_therm_enc.sv | 22 ++
 rtl/dac_power_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_dac_power_sequencer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_seq_pkg.sv
// Shared types and constants for the RGB DAC power sequencer.
package dac_seq_pkg;

    localparam int SEG_COUNT    = 4;
    localparam int SEG_SWITCHES = 3;
    localparam int CODE_W       = SEG_COUNT * SEG_SWITCHES;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_BIAS1,
        ST_BIAS2,
        ST_BIAS3,
        ST_RUN,
        ST_DOWN
    } state_t;

endpackage

// File: rtl/dac_power_sequencer_seg_therm_enc.sv
// Combinational 8-bit channel value to 12-bit segmented thermometer switch code.
module seg_therm_enc
    import dac_seq_pkg::*;
(
    input  logic [7:0]        value,
    output logic [CODE_W-1:0] code
);

    // Each 2-bit slice k turns on the lowest k switches of its segment.
    always_comb begin
        code = '0;
        for (int s = 0; s < SEG_COUNT; s++) begin
            case (value[2*s +: 2])
                2'd1:    code[SEG_SWITCHES*s +: SEG_SWITCHES] = 3'b001;
                2'd2:    code[SEG_SWITCHES*s +: SEG_SWITCHES] = 3'b011;
                2'd3:    code[SEG_SWITCHES*s +: SEG_SWITCHES] = 3'b111;
                default: code[SEG_SWITCHES*s +: SEG_SWITCHES] = 3'b000;
            endcase
        end
    end

endmodule

// File: rtl/dac_power_sequencer.sv
// Sequences the R/G/B DAC biases through power-up, pixel streaming and power-down.
// Optional internal test ramp is built when DAC_SEQ_RAMP_EN is defined.
module dac_power_sequencer
    import dac_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [2:0]        ch_en,
    input  logic              pix_valid,
    input  logic [23:0]       pix_rgb,
    output logic              pix_ready,
    input  logic              blank,
    input  logic              test_mode,
    output logic [CODE_W-1:0] R,
    output logic [CODE_W-1:0] G,
    output logic [CODE_W-1:0] B,
    output logic [2:0]        bias_r,
    output logic [2:0]        bias_g,
    output logic [2:0]        bias_b,
    output logic              running
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        ch_en_q, ch_en_d;
    logic [CODE_W-1:0] r_code_q, r_code_d, g_code_q, g_code_d, b_code_q, b_code_d;
    logic [2:0]        bias_r_q, bias_r_d, bias_g_q, bias_g_d, bias_b_q, bias_b_d;
    logic              pix_ready_q, pix_ready_d;
    logic              running_q, running_d;
    logic              stage_done;
    logic [2:0]        stage_bias;
    logic              ramp_req;
    logic              ramp_active;
    logic [7:0]        ramp_val;
    logic [CODE_W-1:0] enc_r, enc_g, enc_b;

`ifdef DAC_SEQ_RAMP_EN
    logic [7:0] ramp_q, ramp_d;

    assign ramp_req    = test_mode;
    assign ramp_active = test_mode && (state_q == ST_RUN);
    assign ramp_val    = ramp_q;

    // Ramp restarts from 0 whenever it is not actively being shown; blank freezes it.
    always_comb begin
        ramp_d = 8'd0;
        if (ramp_active && (state_d == ST_RUN)) begin
            ramp_d = blank ? ramp_q : ramp_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ramp_q <= 8'd0;
        end else begin
            ramp_q <= ramp_d;
        end
    end
`else
    logic unused_test_mode;

    assign unused_test_mode = test_mode;
    assign ramp_req         = 1'b0;
    assign ramp_active      = 1'b0;
    assign ramp_val         = 8'd0;
`endif

    seg_therm_enc u_enc_r (.value(ramp_active ? ramp_val : pix_rgb[23:16]), .code(enc_r));
    seg_therm_enc u_enc_g (.value(ramp_active ? ramp_val : pix_rgb[15:8]),  .code(enc_g));
    seg_therm_enc u_enc_b (.value(ramp_active ? ramp_val : pix_rgb[7:0]),   .code(enc_b));

    always_comb begin
        state_d    = state_q;
        ch_en_d    = ch_en_q;
        cnt_d      = cnt_q;
        stage_done = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
        case (state_q)
            ST_OFF: begin
                if (enable) begin
                    state_d = ST_BIAS1;
                    ch_en_d = ch_en;
                end
            end
            ST_BIAS1: begin
                if (!enable)         state_d = ST_DOWN;
                else if (stage_done) state_d = ST_BIAS2;
            end
            ST_BIAS2: begin
                if (!enable)         state_d = ST_DOWN;
                else if (stage_done) state_d = ST_BIAS3;
            end
            ST_BIAS3: begin
                if (!enable)         state_d = ST_DOWN;
                else if (stage_done) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!enable) state_d = ST_DOWN;
            end
            ST_DOWN: begin
                if (stage_done) state_d = ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase
        // Counter only runs in timed stages so it never wraps while parked in RUN.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q inside {ST_BIAS1, ST_BIAS2, ST_BIAS3, ST_DOWN}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        r_code_d = r_code_q;
        g_code_d = g_code_q;
        b_code_d = b_code_q;
        if ((state_d != ST_RUN) || (state_q != ST_RUN) || blank) begin
            r_code_d = '0;
            g_code_d = '0;
            b_code_d = '0;
        end else if (ramp_active || (pix_valid && pix_ready_q)) begin
            r_code_d = ch_en_q[0] ? enc_r : '0;
            g_code_d = ch_en_q[1] ? enc_g : '0;
            b_code_d = ch_en_q[2] ? enc_b : '0;
        end

        pix_ready_d = (state_d == ST_RUN) && !ramp_req;
        running_d   = (state_d == ST_RUN);

        case (state_d)
            ST_BIAS1:                  stage_bias = 3'b001;
            ST_BIAS2:                  stage_bias = 3'b011;
            ST_BIAS3, ST_RUN, ST_DOWN: stage_bias = 3'b111;
            default:                   stage_bias = 3'b000;
        endcase
        // During DOWN the biases stay exactly as they were until released in OFF.
        if (state_d == ST_DOWN) begin
            bias_r_d = bias_r_q;
            bias_g_d = bias_g_q;
            bias_b_d = bias_b_q;
        end else begin
            bias_r_d = ch_en_d[0] ? stage_bias : 3'b000;
            bias_g_d = ch_en_d[1] ? stage_bias : 3'b000;
            bias_b_d = ch_en_d[2] ? stage_bias : 3'b000;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_OFF;
            cnt_q       <= '0;
            ch_en_q     <= 3'b000;
            r_code_q    <= '0;
            g_code_q    <= '0;
            b_code_q    <= '0;
            bias_r_q    <= 3'b000;
            bias_g_q    <= 3'b000;
            bias_b_q    <= 3'b000;
            pix_ready_q <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ch_en_q     <= ch_en_d;
            r_code_q    <= r_code_d;
            g_code_q    <= g_code_d;
            b_code_q    <= b_code_d;
            bias_r_q    <= bias_r_d;
            bias_g_q    <= bias_g_d;
            bias_b_q    <= bias_b_d;
            pix_ready_q <= pix_ready_d;
            running_q   <= running_d;
        end
    end

    assign R         = r_code_q;
    assign G         = g_code_q;
    assign B         = b_code_q;
    assign bias_r    = bias_r_q;
    assign bias_g    = bias_g_q;
    assign bias_b    = bias_b_q;
    assign pix_ready = pix_ready_q;
    assign running   = running_q;

endmodule

// File: tb/tb_dac_power_sequencer.sv
// Self-checking bench for dac_power_sequencer with a short settle time.
module tb_dac_power_sequencer;

    localparam int SETTLE = 4;

    typedef struct packed {
        logic [11:0] r;
        logic [11:0] g;
        logic [11:0] b;
    } codes_t;

    logic        clk = 1'b0;
    logic        rst_n, enable, pix_valid, pix_ready, blank, test_mode, running;
    logic [2:0]  ch_en, bias_r, bias_g, bias_b;
    logic [23:0] pix_rgb;
    logic [11:0] r_code, g_code, b_code;

    int     checks = 0;
    int     errors = 0;
    codes_t exp_q[$];
    codes_t last_codes;
    codes_t exp_c;
    logic [2:0] cur_mask;

    always #5 clk = ~clk;

    dac_power_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ch_en(ch_en),
        .pix_valid(pix_valid), .pix_rgb(pix_rgb), .pix_ready(pix_ready),
        .blank(blank), .test_mode(test_mode),
        .R(r_code), .G(g_code), .B(b_code),
        .bias_r(bias_r), .bias_g(bias_g), .bias_b(bias_b), .running(running)
    );

    // Thermometer via shift: 0->000, 1->001, 2->011, 3->111.
    function automatic logic [11:0] enc_model(input logic [7:0] v);
        logic [11:0] c;
        c = '0;
        for (int s = 0; s < 4; s++) begin
            c[3*s +: 3] = 3'b111 >> (3 - int'(v[2*s +: 2]));
        end
        return c;
    endfunction

    function automatic codes_t model_pixel(input logic [23:0] rgb, input logic [2:0] mask);
        codes_t m;
        m.r = mask[0] ? enc_model(rgb[23:16]) : 12'h000;
        m.g = mask[1] ? enc_model(rgb[15:8])  : 12'h000;
        m.b = mask[2] ? enc_model(rgb[7:0])   : 12'h000;
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({r_code, g_code, b_code} !== 36'h0) begin
            errors++;
            $display("[TB] FAIL reset_codes: got %h want 0", {r_code, g_code, b_code});
        end
        checks++;
        if ({bias_r, bias_g, bias_b} !== 9'h0) begin
            errors++;
            $display("[TB] FAIL reset_bias: got %b want 0", {bias_r, bias_g, bias_b});
        end
        checks++;
        if ({pix_ready, running} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_status: got %b want 00", {pix_ready, running});
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({bias_r, bias_g, bias_b, running} !== 10'h0) begin
            errors++;
            $display("[TB] FAIL idle_off: got %b want 0", {bias_r, bias_g, bias_b, running});
        end
    endtask

    task automatic test_power_up();
        logic [2:0] eb;
        logic       er;
        cur_mask = 3'b111;
        ch_en    = cur_mask;
        enable   = 1'b1;
        for (int k = 1; k <= 3*SETTLE + 1; k++) begin
            step();
            eb = (k <= SETTLE) ? 3'b001 : (k <= 2*SETTLE) ? 3'b011 : 3'b111;
            er = (k == 3*SETTLE + 1);
            checks++;
            if ({bias_r, bias_g, bias_b} !== {eb, eb, eb}) begin
                errors++;
                $display("[TB] FAIL power_up_bias k=%0d: got %b want %b", k, {bias_r, bias_g, bias_b}, {eb, eb, eb});
            end
            checks++;
            if ({running, pix_ready} !== {er, er}) begin
                errors++;
                $display("[TB] FAIL power_up_run k=%0d: got %b want %b", k, {running, pix_ready}, {er, er});
            end
        end
        last_codes = '0;
    endtask

    task automatic test_pixels();
        logic [23:0] pix_list [3];
        pix_list[0] = 24'h000000;
        pix_list[1] = 24'hFFFFFF;
        pix_list[2] = 24'h1B2D87;
        pix_rgb   = 24'hE4FF55;
        pix_valid = 1'b1;
        step();
        checks++;
        if ({r_code, g_code, b_code} !== 36'hEC8FFF249) begin
            errors++;
            $display("[TB] FAIL pixel_e4ff55: got %h want EC8FFF249", {r_code, g_code, b_code});
        end
        for (int i = 0; i < 3; i++) begin
            pix_rgb    = pix_list[i];
            last_codes = model_pixel(pix_rgb, cur_mask);
            exp_q.push_back(last_codes);
            step();
            exp_c = exp_q.pop_front();
            checks++;
            if ({r_code, g_code, b_code} !== exp_c) begin
                errors++;
                $display("[TB] FAIL pixel_stream i=%0d: got %h want %h", i, {r_code, g_code, b_code}, exp_c);
            end
        end
        pix_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pix_rgb = 24'($urandom);
            exp_q.push_back(last_codes);
            step();
            exp_c = exp_q.pop_front();
            checks++;
            if ({r_code, g_code, b_code} !== exp_c) begin
                errors++;
                $display("[TB] FAIL pixel_hold i=%0d: got %h want %h", i, {r_code, g_code, b_code}, exp_c);
            end
        end
    endtask

    task automatic test_blank();
        blank      = 1'b1;
        pix_valid  = 1'b1;
        pix_rgb    = 24'hFFFFFF;
        last_codes = '0;
        exp_q.push_back(last_codes);
        step();
        exp_c = exp_q.pop_front();
        checks++;
        if ({r_code, g_code, b_code} !== exp_c) begin
            errors++;
            $display("[TB] FAIL blank_codes: got %h want %h", {r_code, g_code, b_code}, exp_c);
        end
        checks++;
        if (pix_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL blank_ready: got %b want 1", pix_ready);
        end
        blank     = 1'b0;
        pix_valid = 1'b0;
        exp_q.push_back(last_codes);
        step();
        exp_c = exp_q.pop_front();
        checks++;
        if ({r_code, g_code, b_code} !== exp_c) begin
            errors++;
            $display("[TB] FAIL blank_release: got %h want %h", {r_code, g_code, b_code}, exp_c);
        end
        pix_valid  = 1'b1;
        pix_rgb    = 24'h3C69A5;
        last_codes = model_pixel(pix_rgb, cur_mask);
        exp_q.push_back(last_codes);
        step();
        exp_c = exp_q.pop_front();
        checks++;
        if ({r_code, g_code, b_code} !== exp_c) begin
            errors++;
            $display("[TB] FAIL blank_recover: got %h want %h", {r_code, g_code, b_code}, exp_c);
        end
        pix_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            pix_valid = ($urandom_range(0, 3) != 0);
            pix_rgb   = 24'($urandom);
            if (pix_valid) last_codes = model_pixel(pix_rgb, cur_mask);
            exp_q.push_back(last_codes);
            step();
            exp_c = exp_q.pop_front();
            checks++;
            if ({r_code, g_code, b_code} !== exp_c) begin
                errors++;
                $display("[TB] FAIL b2b_codes i=%0d: got %h want %h", i, {r_code, g_code, b_code}, exp_c);
            end
            checks++;
            if (pix_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_ready i=%0d: got %b want 1", i, pix_ready);
            end
        end
        pix_valid = 1'b0;
    endtask

`ifdef DAC_SEQ_RAMP_EN
    task automatic test_ramp();
        logic [11:0] e;
        pix_valid = 1'b0;
        test_mode = 1'b1;
        for (int k = 1; k <= 260; k++) begin
            step();
            e = enc_model(8'(k - 1));
            checks++;
            if ({r_code, g_code, b_code} !== {e, e, e}) begin
                errors++;
                $display("[TB] FAIL ramp_codes k=%0d: got %h want %h", k, {r_code, g_code, b_code}, {e, e, e});
            end
            checks++;
            if (pix_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL ramp_ready k=%0d: got %b want 0", k, pix_ready);
            end
        end
        test_mode  = 1'b0;
        last_codes = {enc_model(8'd3), enc_model(8'd3), enc_model(8'd3)};
        exp_q.push_back(last_codes);
        step();
        exp_c = exp_q.pop_front();
        checks++;
        if ({r_code, g_code, b_code, pix_ready} !== {exp_c, 1'b1}) begin
            errors++;
            $display("[TB] FAIL ramp_exit: got %h/%b want %h/1", {r_code, g_code, b_code}, pix_ready, exp_c);
        end
    endtask
`else
    task automatic test_mode_ignored();
        test_mode  = 1'b1;
        pix_valid  = 1'b1;
        pix_rgb    = 24'h5AC3F0;
        last_codes = model_pixel(pix_rgb, cur_mask);
        exp_q.push_back(last_codes);
        step();
        exp_c = exp_q.pop_front();
        checks++;
        if ({r_code, g_code, b_code, pix_ready} !== {exp_c, 1'b1}) begin
            errors++;
            $display("[TB] FAIL test_mode_ignored: got %h/%b want %h/1", {r_code, g_code, b_code}, pix_ready, exp_c);
        end
        test_mode = 1'b0;
        pix_valid = 1'b0;
    endtask
`endif

    task automatic test_power_down();
        logic [2:0] eb;
        logic       er;
        pix_valid  = 1'b1;
        pix_rgb    = 24'h123456;
        last_codes = model_pixel(pix_rgb, cur_mask);
        exp_q.push_back(last_codes);
        step();
        exp_c = exp_q.pop_front();
        checks++;
        if ({r_code, g_code, b_code} !== exp_c) begin
            errors++;
            $display("[TB] FAIL pre_down_pixel: got %h want %h", {r_code, g_code, b_code}, exp_c);
        end
        pix_valid = 1'b0;
        enable    = 1'b0;
        for (int k = 1; k <= 4*SETTLE + 2; k++) begin
            step();
            if (k <= SETTLE)              eb = 3'b111;
            else if (k == SETTLE + 1)     eb = 3'b000;
            else if (k <= 2*SETTLE + 1)   eb = 3'b001;
            else if (k <= 3*SETTLE + 1)   eb = 3'b011;
            else                          eb = 3'b111;
            er = (k == 4*SETTLE + 2);
            checks++;
            if ({bias_r, bias_g, bias_b} !== {eb, eb, eb}) begin
                errors++;
                $display("[TB] FAIL down_bias k=%0d: got %b want %b", k, {bias_r, bias_g, bias_b}, {eb, eb, eb});
            end
            checks++;
            if ({r_code, g_code, b_code, running, pix_ready} !== {36'h0, er, er}) begin
                errors++;
                $display("[TB] FAIL down_status k=%0d: got %h/%b%b want 0/%b%b", k, {r_code, g_code, b_code}, running, pix_ready, er, er);
            end
            if (k == 2) enable = 1'b1;
        end
        last_codes = '0;
    endtask

    task automatic test_channel_mask();
        enable = 1'b0;
        repeat (SETTLE + 1) step();
        checks++;
        if ({bias_r, bias_g, bias_b, running} !== 10'h0) begin
            errors++;
            $display("[TB] FAIL mask_off: got %b want 0", {bias_r, bias_g, bias_b, running});
        end
        cur_mask = 3'b010;
        ch_en    = cur_mask;
        enable   = 1'b1;
        step();
        ch_en = 3'b111;
        repeat (3*SETTLE) step();
        checks++;
        if ({running, bias_r, bias_g, bias_b} !== {1'b1, 3'b000, 3'b111, 3'b000}) begin
            errors++;
            $display("[TB] FAIL mask_bias: got %b want 1000111000", {running, bias_r, bias_g, bias_b});
        end
        pix_valid  = 1'b1;
        pix_rgb    = 24'hFFFFFF;
        last_codes = model_pixel(pix_rgb, cur_mask);
        exp_q.push_back(last_codes);
        step();
        exp_c = exp_q.pop_front();
        checks++;
        if ({r_code, g_code, b_code} !== exp_c) begin
            errors++;
            $display("[TB] FAIL mask_codes: got %h want %h", {r_code, g_code, b_code}, exp_c);
        end
        checks++;
        if ({r_code, g_code, b_code} !== 36'h000FFF000) begin
            errors++;
            $display("[TB] FAIL mask_green_only: got %h want 000FFF000", {r_code, g_code, b_code});
        end
        pix_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        enable = 1'b0;
        repeat (SETTLE + 1) step();
        cur_mask = 3'b111;
        ch_en    = cur_mask;
        enable   = 1'b1;
        repeat (SETTLE + 2) step();
        checks++;
        if ({bias_r, bias_g, bias_b} !== 9'b011011011) begin
            errors++;
            $display("[TB] FAIL mid_bias2: got %b want 011011011", {bias_r, bias_g, bias_b});
        end
        rst_n  = 1'b0;
        enable = 1'b0;
        step();
        checks++;
        if ({r_code, g_code, b_code, bias_r, bias_g, bias_b, pix_ready, running} !== 47'h0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got bias %b status %b%b want 0", {bias_r, bias_g, bias_b}, pix_ready, running);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({bias_r, bias_g, bias_b, running} !== 10'h0) begin
            errors++;
            $display("[TB] FAIL mid_no_down: got %b want 0", {bias_r, bias_g, bias_b, running});
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        ch_en      = 3'b000;
        pix_valid  = 1'b0;
        pix_rgb    = 24'h0;
        blank      = 1'b0;
        test_mode  = 1'b0;
        cur_mask   = 3'b000;
        last_codes = '0;
        $display("[TB] starting dac_power_sequencer bench");
        test_reset();
        test_power_up();
        test_pixels();
        test_blank();
        test_back_to_back();
`ifdef DAC_SEQ_RAMP_EN
        test_ramp();
`else
        test_mode_ignored();
`endif
        test_power_down();
        test_channel_mask();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
